// File: rtl/pll_pkg.sv
// Shared PLL constants and a signed saturating clamp.
// Callers sign-extend their operands to SAT_W before clamping.
package pll_pkg;

  localparam logic [31:0] FCW_NOM = 32'h0100_0000;
  localparam logic [31:0] FCW_MIN = 32'h0080_0000;
  localparam logic [31:0] FCW_MAX = 32'h0200_0000;
  localparam logic [31:0] INT_LIM = 32'h0100_0000;

  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_clamp(
    input logic signed [SAT_W-1:0] x,
    input logic signed [SAT_W-1:0] lo,
    input logic signed [SAT_W-1:0] hi
  );
    if (x < lo) return lo;
    else if (x > hi) return hi;
    else return x;
  endfunction

endpackage

// File: rtl/dco_feedback_gen_if.sv
// Error-sample input and feedback/status outputs of the DCO.
// master drives the error strobe side; slave is the DCO itself.
interface dco_feedback_gen_if #(
  parameter int WIDTH = 24,
  parameter int ACC_W = 32
);
  logic                    en;
  logic                    err_en;
  logic signed [WIDTH-1:0] err;
  logic                    v_pulse;
  logic                    v_clk;
  logic [ACC_W-1:0]        fcw;
  logic                    locked;

  modport master (
    output en, err_en, err,
    input  v_pulse, v_clk, fcw, locked
  );

  modport slave (
    input  en, err_en, err,
    output v_pulse, v_clk, fcw, locked
  );
endinterface

// File: rtl/nco_phase_acc.sv
// Phase-accumulator NCO: phase += fcw each enabled cycle; carry becomes v_pulse.
// One cycle from wrap to v_pulse; en low freezes phase and forces v_pulse low.
module nco_phase_acc #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] fcw,
  output logic             v_pulse,
  output logic             v_clk
);

  logic [ACC_W-1:0] phase;
  logic [ACC_W:0]   sum;

  assign sum   = {1'b0, phase} + {1'b0, fcw};
  assign v_clk = phase[ACC_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= '0;
      v_pulse <= 1'b0;
    end else if (en) begin
      phase   <= sum[ACC_W-1:0];
      v_pulse <= sum[ACC_W];
    end else begin
      v_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/dco_feedback_gen.sv
// PI loop filter + NCO regenerating the PFD feedback pulse, with lock detector.
// Sample edge N: filter state at N+1, fcw at N+2; en low freezes everything.
module dco_feedback_gen #(
  parameter int               WIDTH    = 24,
  parameter int               ACC_W    = 32,
  parameter int               KP_SH    = 2,
  parameter int               KI_SH    = 6,
  parameter logic [ACC_W-1:0] FCW_NOM  = pll_pkg::FCW_NOM,
  parameter logic [ACC_W-1:0] FCW_MIN  = pll_pkg::FCW_MIN,
  parameter logic [ACC_W-1:0] FCW_MAX  = pll_pkg::FCW_MAX,
  parameter logic [ACC_W-1:0] INT_LIM  = pll_pkg::INT_LIM,
  parameter int               LOCK_TOL = 4,
  parameter int               LOCK_N   = 8
) (
  input logic               clk,
  input logic               rst,
  dco_feedback_gen_if.slave bus
);

  import pll_pkg::*;

  localparam int SUM_W = ACC_W + 2;
  localparam int CNT_W = $clog2(LOCK_N + 1);

  localparam logic signed [SAT_W-1:0] INT_HI = SAT_W'(INT_LIM);
  localparam logic signed [SAT_W-1:0] INT_LO = -INT_HI;
  localparam logic signed [SAT_W-1:0] FCW_HI = SAT_W'(FCW_MAX);
  localparam logic signed [SAT_W-1:0] FCW_LO = SAT_W'(FCW_MIN);
  localparam logic signed [SUM_W-1:0] NOM_S  = SUM_W'(FCW_NOM);

  logic                    err_en_d;
  logic                    sample;
  logic signed [ACC_W-1:0] err_ext;
  logic signed [ACC_W-1:0] p_term;
  logic signed [ACC_W-1:0] i_term;
  logic signed [ACC_W-1:0] p_reg;
  logic signed [ACC_W-1:0] int_acc;
  logic signed [ACC_W-1:0] int_next;
  logic signed [SUM_W-1:0] int_sum;
  logic signed [SUM_W-1:0] fcw_sum;
  logic [ACC_W-1:0]        fcw_next;
  logic [ACC_W-1:0]        fcw_q;
  logic signed [WIDTH:0]   err_w;
  logic [WIDTH:0]          err_abs;
  logic                    in_tol;
  logic [CNT_W-1:0]        lock_cnt;
  logic                    locked_q;

  // Only the rising edge of the strobe counts, and only while enabled.
  assign sample = bus.en & bus.err_en & ~err_en_d;

  assign err_ext = {{(ACC_W-WIDTH){bus.err[WIDTH-1]}}, bus.err};
  assign p_term  = err_ext >>> KP_SH;
  assign i_term  = err_ext >>> KI_SH;

  // Extra headroom bits guarantee the sums saturate rather than wrap.
  assign int_sum  = SUM_W'(int_acc) + SUM_W'(i_term);
  assign int_next = ACC_W'(sat_clamp(SAT_W'(int_sum), INT_LO, INT_HI));
  assign fcw_sum  = NOM_S + SUM_W'(int_acc) + SUM_W'(p_reg);
  assign fcw_next = ACC_W'(sat_clamp(SAT_W'(fcw_sum), FCW_LO, FCW_HI));

  assign err_w   = {bus.err[WIDTH-1], bus.err};
  assign err_abs = err_w[WIDTH] ? -err_w : err_w;
  assign in_tol  = (err_abs <= (WIDTH+1)'(LOCK_TOL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_en_d <= 1'b0;
      p_reg    <= '0;
      int_acc  <= '0;
      fcw_q    <= FCW_NOM;
    end else if (bus.en) begin
      err_en_d <= bus.err_en;
      fcw_q    <= fcw_next;
      if (sample) begin
        p_reg   <= p_term;
        int_acc <= int_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
      locked_q <= 1'b0;
    end else if (sample) begin
      if (in_tol) begin
        if (lock_cnt < CNT_W'(LOCK_N)) lock_cnt <= lock_cnt + 1'b1;
        if (lock_cnt >= CNT_W'(LOCK_N - 1)) locked_q <= 1'b1;
      end else begin
        lock_cnt <= '0;
        locked_q <= 1'b0;
      end
    end
  end

  assign bus.fcw    = fcw_q;
  assign bus.locked = locked_q;

  nco_phase_acc #(
    .ACC_W (ACC_W)
  ) u_nco (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .fcw     (fcw_q),
    .v_pulse (bus.v_pulse),
    .v_clk   (bus.v_clk)
  );

endmodule

// File: tb/tb_dco_feedback_gen.sv
// Directed bench for dco_feedback_gen: single-sample vector table plus
// free-run, hold, lock, freeze, saturation and async-reset sequences.
module tb_dco_feedback_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dco_feedback_gen_if #(.WIDTH(24), .ACC_W(32)) bus ();

  dco_feedback_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [23:0] err;
    logic [31:0] p;
    logic [31:0] i;
    logic [31:0] fcw;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.en = 1'b1;
    bus.err_en = 1'b0;
    bus.err = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic sample(input logic [23:0] e);
    bus.err = e;
    bus.err_en = 1'b1;
    tick();
    bus.err_en = 1'b0;
    tick();
  endtask

  initial begin
    int first_p, second_p, n_p, vh, vl, bad_v, t1, t2;
    logic [31:0] ph, f, ia;

    vecs[0] = '{24'h000040, 32'h0000_0010, 32'h0000_0001, 32'h0100_0011};
    vecs[1] = '{24'hFFFFC0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h00FF_FFEF};
    vecs[2] = '{24'h000064, 32'h0000_0019, 32'h0000_0001, 32'h0100_001A};
    vecs[3] = '{24'hFFFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h00FF_FFFE};
    vecs[4] = '{24'h000000, 32'h0000_0000, 32'h0000_0000, 32'h0100_0000};
    vecs[5] = '{24'h7FFFFF, 32'h001F_FFFF, 32'h0001_FFFF, 32'h0121_FFFE};
    vecs[6] = '{24'h800000, 32'hFFE0_0000, 32'hFFFE_0000, 32'h00DE_0000};
    vecs[7] = '{24'h0003E8, 32'h0000_00FA, 32'h0000_000F, 32'h0100_0109};

    rst = 1'b1;
    bus.en = 1'b1;
    bus.err_en = 1'b0;
    bus.err = '0;
    tick();
    chk("reset_fcw", bus.fcw, 32'h0100_0000);
    chk("reset_v_pulse", 32'(bus.v_pulse), 32'd0);
    chk("reset_locked", 32'(bus.locked), 32'd0);
    chk("reset_v_clk", 32'(bus.v_clk), 32'd0);

    // Free run at nominal FCW.
    do_reset();
    first_p = -1; second_p = -1; n_p = 0; vh = -1; vl = -1;
    for (int k = 1; k <= 600; k++) begin
      tick();
      if (bus.v_pulse) begin
        n_p++;
        if (first_p < 0) first_p = k;
        else if (second_p < 0) second_p = k;
      end
      if (bus.v_clk && vh < 0) vh = k;
      if (vh >= 0 && !bus.v_clk && vl < 0) vl = k;
    end
    chk("free_first_pulse", 32'(first_p), 32'd256);
    chk("free_second_pulse", 32'(second_p), 32'd512);
    chk("free_pulse_count", 32'(n_p), 32'd2);
    chk("free_v_clk_rise", 32'(vh), 32'd128);
    chk("free_v_clk_fall", 32'(vl), 32'd256);
    chk("free_fcw", bus.fcw, 32'h0100_0000);

    // One sample from reset per vector.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      bus.err = vecs[v].err;
      bus.err_en = 1'b1;
      tick();
      chk($sformatf("vec%0d_fcw_n1", v), bus.fcw, 32'h0100_0000);
      chk($sformatf("vec%0d_p_reg", v), dut.p_reg, vecs[v].p);
      chk($sformatf("vec%0d_int_acc", v), dut.int_acc, vecs[v].i);
      tick();
      chk($sformatf("vec%0d_fcw_n2", v), bus.fcw, vecs[v].fcw);
      bus.err_en = 1'b0;
    end

    // Strobe held high for 5 cycles yields one sample.
    do_reset();
    bus.err = 24'd64;
    bus.err_en = 1'b1;
    repeat (5) tick();
    bus.err_en = 1'b0;
    tick();
    chk("hold_int_acc", dut.int_acc, 32'd1);
    chk("hold_p_reg", dut.p_reg, 32'd16);
    chk("hold_fcw", bus.fcw, 32'h0100_0011);

    // Lock, drop, re-lock.
    do_reset();
    for (int s = 0; s < 7; s++) sample((s % 2) ? 24'h000003 : 24'hFFFFFD);
    chk("lock_after7", 32'(bus.locked), 32'd0);
    bus.err = 24'h000003;
    bus.err_en = 1'b1;
    tick();
    chk("lock_after8", 32'(bus.locked), 32'd1);
    bus.err_en = 1'b0;
    tick();
    bus.err = 24'h000005;
    bus.err_en = 1'b1;
    tick();
    chk("lock_drop", 32'(bus.locked), 32'd0);
    bus.err_en = 1'b0;
    tick();
    for (int s = 0; s < 7; s++) sample(24'hFFFFFC);
    chk("relock_after7", 32'(bus.locked), 32'd0);
    sample(24'h000004);
    chk("relock_after8", 32'(bus.locked), 32'd1);

    // Asynchronous reset between edges while locked.
    repeat (37) tick();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_locked", 32'(bus.locked), 32'd0);
    chk("arst_v_pulse", 32'(bus.v_pulse), 32'd0);
    chk("arst_phase", dut.u_nco.phase, 32'd0);
    chk("arst_fcw", bus.fcw, 32'h0100_0000);
    @(negedge clk);
    rst = 1'b0;

    // en freeze with a lost strobe edge.
    do_reset();
    repeat (100) tick();
    sample(24'd64);
    repeat (3) tick();
    bus.en = 1'b0;
    ph = dut.u_nco.phase;
    f = bus.fcw;
    ia = dut.int_acc;
    bad_v = 0;
    for (int k = 0; k < 50; k++) begin
      if (k == 10) begin bus.err = 24'd1000; bus.err_en = 1'b1; end
      if (k == 20) bus.err_en = 1'b0;
      tick();
      if (bus.v_pulse) bad_v++;
    end
    chk("freeze_phase", dut.u_nco.phase, ph);
    chk("freeze_fcw", bus.fcw, f);
    chk("freeze_v_pulse_hi", 32'(bad_v), 32'd0);
    bus.en = 1'b1;
    tick();
    chk("resume_phase", dut.u_nco.phase, ph + 32'h0100_0011);
    tick();
    chk("freeze_no_sample", dut.int_acc, 32'd1);

    // Saturation both ways.
    do_reset();
    for (int s = 0; s < 1000; s++) sample(24'h7FFFFF);
    chk("sat_int_pos", dut.int_acc, 32'h0100_0000);
    chk("sat_fcw_max", bus.fcw, 32'h0200_0000);
    t1 = -1; t2 = -1;
    for (int k = 0; k < 300 && t2 < 0; k++) begin
      tick();
      if (bus.v_pulse) begin
        if (t1 < 0) t1 = k;
        else t2 = k;
      end
    end
    chk("sat_pulse_period", 32'(t2 - t1), 32'd128);
    for (int s = 0; s < 1000; s++) sample(24'h800000);
    chk("sat_int_neg", dut.int_acc, 32'hFF00_0000);
    chk("sat_fcw_min", bus.fcw, 32'h0080_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dco_feedback_gen.md
# dco_feedback_gen

Digitally controlled oscillator that sits at the opposite end of the loop from the frequency-error detector in the dual-FF PFD PLL. It consumes signed error words plus their valid strobe and filters them through a proportional-integral loop filter. The filtered value steers a phase-accumulator NCO, which regenerates the feedback pulse `V` that returns to the PFD and error counter. A lock detector flags when the error has stayed small for a programmable run of samples.

## Interface
- `WIDTH`, 24: signed error word width.
- `ACC_W`, 32: phase accumulator, integrator and FCW width.
- `KP_SH`, 2: proportional gain, as an arithmetic right shift of `err`.
- `KI_SH`, 6: integral gain, as an arithmetic right shift of `err`.
- `FCW_NOM`, 32'h0100_0000: nominal frequency control word.
- `FCW_MIN` / `FCW_MAX`, 32'h0080_0000 / 32'h0200_0000: FCW clamp bounds.
- `INT_LIM`, 32'h0100_0000: integrator clamp, symmetric ±`INT_LIM`.
- `LOCK_TOL`, 4: lock tolerance on |err|.
- `LOCK_N`, 8: consecutive in-tolerance samples required to declare lock.

Ports (`rst` is asynchronous, active-high):
- `clk` in 1: single clock.
- `rst` in 1: asynchronous reset, active-high.
- `en` in 1: clock enable; low freezes all state.
- `err_en` in 1: error valid strobe.
- `err` in `WIDTH`: signed frequency error; positive means the reference is faster than `V`.
- `v_pulse` out 1: registered one-cycle feedback pulse, driven to the PFD `V` input.
- `v_clk` out 1: phase MSB, a ~50% duty feedback clock.
- `fcw` out `ACC_W`: current frequency control word.
- `locked` out 1: lock indicator.

## Operation
- **Sample qualification:**
  - A sample is taken only when `en & err_en & ~err_en_d`, i.e. on the rising edge of the strobe.
  - `err_en_d` updates only while `en` is high.
  - Holding `err_en` high for several cycles yields exactly one sample.
- **Loop filter, on each sample:**
  - `p_reg <= err >>> KP_SH`, sign-extended to `ACC_W`.
  - `int_acc <= clamp(int_acc + (err >>> KI_SH), -INT_LIM, +INT_LIM)`.
  - Sums are computed at `ACC_W+2` bits and clamped before truncation; the value never wraps.
  - `p_reg` holds its value between samples.
- **FCW:** `fcw <= clamp(FCW_NOM + int_acc + p_reg, FCW_MIN, FCW_MAX)`. It is computed at `ACC_W+2` bits and registered every `en` cycle.
- **NCO:**
  - Each `en` cycle, `phase <= phase + fcw`, modulo 2^`ACC_W`.
  - `v_pulse <= carry_out` of that add.
  - `v_clk = phase[ACC_W-1]`.
- **Lock detector:**
  - In-tolerance sample (|err| ≤ `LOCK_TOL`): `lock_cnt` increments, saturating at `LOCK_N`.
  - `locked <= 1` when `lock_cnt` reaches `LOCK_N`.
  - Out-of-tolerance sample: `lock_cnt <= 0` and `locked <= 0`.
- **`en` low:**
  - `phase`, `int_acc`, `p_reg`, `fcw`, `lock_cnt` and `locked` all hold.
  - `v_pulse` is forced to 0.
  - A strobe edge arriving while `en` is low is lost.
- **Reset values:** `phase` 0, `int_acc` 0, `p_reg` 0, `fcw` `FCW_NOM`, `v_pulse` 0, `locked` 0, `lock_cnt` 0, `err_en_d` 0.

## Timing
- **Sample at edge N:**
  - `p_reg` and `int_acc` update at N+1.
  - `fcw` updates at N+2.
  - The phase increment first uses the new `fcw` at N+3.
- **`v_pulse`:** goes high the cycle after the accumulator wraps and lasts exactly one cycle. With constant `fcw`, the pulse period is 2^`ACC_W`/`fcw` cycles, averaged.
- **`locked`:** asserts one cycle after the `LOCK_N`th consecutive in-tolerance sample. It deasserts one cycle after a failing sample.
- **Reset mid-operation:** all outputs take their reset values immediately, asynchronously. The first `v_pulse` after release comes 2^`ACC_W`/`FCW_NOM` cycles later.
- **Simultaneous clamps:** the integrator clamp and the FCW clamp apply independently in the same cycle. The integrator stays at its limit and does not wind up past it.

## Structure
- Shared package `pll_pkg`:
  - default constants `FCW_NOM`, `FCW_MIN`, `FCW_MAX`, `INT_LIM`;
  - a signed saturate/clamp function, parameterised by width.
- Natural sub-module: `nco_phase_acc`, containing the phase register, the adder with carry-out, `v_pulse`/`v_clk` generation and the `en` gating.
- The loop filter and lock detector stay in the top level.

## Test plan
- **Free run:** reset, `en`=1, `err_en`=0 → `fcw`=0x0100_0000; `v_pulse` at cycle 256 after reset release, then every 256 cycles; `v_clk` toggles every 128 cycles.
- **Single sample:** `err`=+64 with `err_en` high for 5 cycles → one sample only; `p_reg`=16, `int_acc`=1; `fcw`=0x0100_0011 two cycles after the edge.
- **Saturation:** 1000 samples of `err`=0x7FFFFF → `int_acc` stops at +0x0100_0000; `fcw` pinned at 0x0200_0000; `v_pulse` every 128 cycles; no wrap.
- **Lock:** 8 samples of `err`=±3 → `locked`=1 one cycle after the 8th; then `err`=5 → `locked`=0, and 8 more in-tolerance samples are required to re-lock.
- **`en` freeze:** `en`=0 for 50 cycles mid-run → `phase` and `fcw` unchanged; `v_pulse`=0; a strobe edge during the freeze produces no sample.
- **Asynchronous reset mid-run:** assert `rst` between clock edges with `locked`=1 → `locked`, `v_pulse`, `phase` clear immediately and `fcw`=`FCW_NOM`.
